spike_aer_encoder: RTL

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spike_aer_encoder.sv
// -----------------------------------------------------------------------------
// spike_aer_encoder
// Turns one parallel spike vector per clock into a serial stream of
// Address-Event-Representation (AER) events {neuron index, timestep}.
// A capture register holds one vector. A lowest-index-first scanner moves its
// set bits into a show-ahead event FIFO, one bit per cycle. A vector that
// arrives while the capture register is still occupied is dropped and counted.
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   spikes      per-neuron spike bits for the current timestep
//   aer_valid   FIFO head holds an event
//   aer_ready   consumer accepts the head event
//   aer_addr    neuron index of the head event
//   aer_ts      timestep of the head event
//   fifo_count  number of events held in the FIFO
//   drop_cnt    saturating count of dropped spike vectors
//   busy        capture register or FIFO is non-empty
// -----------------------------------------------------------------------------
module spike_aer_encoder #(
   parameter int unsigned N_NEURONS  = 8,
   parameter int unsigned TS_WIDTH   = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_NEURONS-1:0]          spikes,
   output logic                          aer_valid,
   input  logic                          aer_ready,
   output logic [$clog2(N_NEURONS)-1:0]  aer_addr,
   output logic [TS_WIDTH-1:0]           aer_ts,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   drop_cnt,
   output logic                          busy
);

   localparam int unsigned AW = $clog2(N_NEURONS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = AW + TS_WIDTH;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // Timestep counter and capture register
   logic [TS_WIDTH-1:0]  ts_cnt;
   logic [N_NEURONS-1:0] cap_vec;
   logic [TS_WIDTH-1:0]  cap_ts;

   // Event FIFO storage and pointers
   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;

   // Per-cycle decisions
   logic [AW-1:0]        scan_idx;
   logic [N_NEURONS-1:0] cap_rest;
   logic                 cap_busy;
   logic                 fifo_full;
   logic                 pop;
   logic                 push;
   logic                 spike_in;
   logic                 load;
   logic                 drop;

   // Lowest set bit of the capture vector; descending loop so the lowest wins
   always_comb begin
      scan_idx = '0;
      for (int i = N_NEURONS - 1; i >= 0; i--) begin
         if (cap_vec[i]) begin
            scan_idx = AW'(i);
         end
      end
   end

   // Push/pop/load/drop decisions for this edge
   always_comb begin
      cap_busy  = (cap_vec != '0);
      fifo_full = (fifo_count == DEPTH_C);
      pop       = aer_valid && aer_ready;
      // A full FIFO still takes a write when the head leaves on the same edge
      push      = cap_busy && (!fifo_full || pop);
      // x & (x-1) clears exactly the lowest set bit, i.e. the one being pushed
      cap_rest  = push ? (cap_vec & (cap_vec - N_NEURONS'(1))) : cap_vec;
      spike_in  = (spikes != '0);
      // Accept a new vector only if the capture is empty after this edge
      load      = spike_in && (cap_rest == '0);
      drop      = spike_in && (cap_rest != '0);
   end

   // Timestep counter, capture register, FIFO bookkeeping, drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt     <= '0;
         cap_vec    <= '0;
         cap_ts     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_cnt   <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_WIDTH'(1);

         if (load) begin
            cap_vec <= spikes;
            cap_ts  <= ts_cnt;
         end else begin
            cap_vec <= cap_rest;
         end

         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         // Simultaneous push and pop leaves the count unchanged
         if (push && !pop) begin
            fifo_count <= fifo_count + CW'(1);
         end else if (pop && !push) begin
            fifo_count <= fifo_count - CW'(1);
         end

         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // FIFO storage; not reset, pointers define which entries are live
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= {scan_idx, cap_ts};
      end
   end

   // Show-ahead head and status
   always_comb begin
      {aer_addr, aer_ts} = mem[rd_ptr];
      aer_valid          = (fifo_count != '0);
      busy               = cap_busy || (fifo_count != '0);
   end

endmodule
